// File: rtl/apb_timer.sv
// apb_timer: APB3 slave with TIM_NUM prescaled up-counting timers, compare/overflow flags and irqs
module apb_timer #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIM_NUM        = 2,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [APB_DATA_WIDTH-1:0] pwdata,
  input  logic                      pwrite,
  input  logic                      psel,
  input  logic                      penable,
  output logic [APB_DATA_WIDTH-1:0] prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic [TIM_NUM*2-1:0]      irq
);
  logic access, err, wr_ok, rd_ok, unused_ok;
  logic [3:0] tsel;
  logic [1:0] rsel;
  logic [TIM_NUM-1:0][APB_DATA_WIDTH-1:0] rd;
  assign access = psel & penable;
  assign tsel = paddr[7:4];
  assign rsel = paddr[3:2];
  assign err = access & (({1'b0, tsel} >= 5'(TIM_NUM)) | (paddr[1:0] != 2'b00));
  assign wr_ok = access & pwrite & ~err;
  assign rd_ok = access & ~pwrite & ~err;
  assign pready = access;
  assign pslverr = err;
  assign unused_ok = ^{paddr, pwdata};
  always_comb begin
    prdata = '0;
    for (int k = 0; k < TIM_NUM; k++)
      if (rd_ok && tsel == 4'(k)) prdata = rd[k];
  end
  for (genvar i = 0; i < TIM_NUM; i++) begin : g_tim
    logic [CNT_WIDTH-1:0] cnt, cmp;
    logic [7:0] presc, pcnt;
    logic en, clr, ovf_ie, cmp_ie, wsel, tick, eq;
    logic [1:0] status, irq_r, set;
    assign wsel = wr_ok & (tsel == 4'(i));
    assign tick = en & (pcnt == presc);
    assign eq = cnt == cmp;
    // compare outranks overflow, so an all-ones match never raises the overflow flag
    assign set = {tick & eq, tick & ~eq & (&cnt)};
    assign rd[i] = rsel == 2'd0 ? APB_DATA_WIDTH'(cnt) :
                   rsel == 2'd1 ? APB_DATA_WIDTH'(cmp) :
                   rsel == 2'd2 ? APB_DATA_WIDTH'({presc, 4'b0, cmp_ie, ovf_ie, clr, en}) :
                                  APB_DATA_WIDTH'(status);
    assign irq[2*i +: 2] = irq_r;
    always_ff @(posedge pclk or negedge presetn)
      if (!presetn) begin
        cnt <= '0;
        cmp <= '0;
        presc <= '0;
        pcnt <= '0;
        en <= 1'b0;
        clr <= 1'b0;
        ovf_ie <= 1'b0;
        cmp_ie <= 1'b0;
        status <= '0;
        irq_r <= '0;
      end else begin
        if (wsel && rsel == 2'd0) cnt <= pwdata[CNT_WIDTH-1:0];
        else if (tick) cnt <= (eq & clr) ? '0 : cnt + 1'b1;
        if (wsel && rsel == 2'd1) cmp <= pwdata[CNT_WIDTH-1:0];
        if (wsel && rsel == 2'd2) begin
          en <= pwdata[0];
          clr <= pwdata[1];
          ovf_ie <= pwdata[2];
          cmp_ie <= pwdata[3];
          presc <= pwdata[15:8];
        end
        pcnt <= (tick || (wsel && rsel == 2'd2 && !pwdata[0])) ? '0 : en ? pcnt + 1'b1 : pcnt;
        status <= (status & ~((wsel && rsel == 2'd3) ? pwdata[1:0] : 2'b00)) | set;
        irq_r <= status & {cmp_ie, ovf_ie};
      end
  end
endmodule

// File: tb/tb_apb_timer.sv
// tb_apb_timer: directed table plus timed sequences for the apb_timer register, prescaler and irq behaviour
module tb_apb_timer;
  logic        pclk = 1'b0, presetn = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic        pwrite = 1'b0, psel = 1'b0, penable = 1'b0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [3:0]  irq;
  int          checks = 0, errors = 0;
  logic [31:0] r;
  logic        e;

  apb_timer dut (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .psel(psel), .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr), .irq(irq)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    logic        err;
  } vec_t;
  vec_t vt[$];

  function automatic void add(input logic wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] rdat, input logic er);
    vt.push_back('{wr, a, d, rdat, er});
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask

  // caller sits just after a rising edge; the access commits two edges later
  task automatic apb(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rdat, output logic er);
    psel = 1'b1; pwrite = wr; paddr = a; pwdata = d; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1;
    #1;
    chk("pready", 32'(pready), 32'h1);
    rdat = prdata;
    er = pslverr;
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rr;
    logic        ee;
    apb(1'b1, a, d, rr, ee);
    chk("wr_err", 32'(ee), 32'h0);
  endtask

  task automatic rdc(input string n, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rr;
    logic        ee;
    apb(1'b0, a, 32'h0, rr, ee);
    chk(n, rr, exp);
    chk({n, "_err"}, 32'(ee), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 32; a += 4) add(1'b0, 32'(a), 32'h0, 32'h0, 1'b0);
    add(1'b1, 32'h04, 32'h55, 32'h0, 1'b0);
    add(1'b0, 32'h04, 32'h0, 32'h55, 1'b0);
    add(1'b1, 32'h08, 32'h8000_0000, 32'h0, 1'b0);
    add(1'b0, 32'h08, 32'h0, 32'h0, 1'b0);
    add(1'b1, 32'h18, 32'hFFFF_FFF0, 32'h0, 1'b0);
    add(1'b0, 32'h18, 32'h0, 32'h0000_FF00, 1'b0);
    add(1'b1, 32'h18, 32'h0, 32'h0, 1'b0);
    add(1'b1, 32'h14, 32'hA5A5_5A5A, 32'h0, 1'b0);
    add(1'b0, 32'h14, 32'h0, 32'hA5A5_5A5A, 1'b0);
    add(1'b1, 32'h10, 32'h1234_5678, 32'h0, 1'b0);
    add(1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b0);
    add(1'b1, 32'h20, 32'hDEAD, 32'h0, 1'b1);
    add(1'b0, 32'h20, 32'h0, 32'h0, 1'b1);
    add(1'b1, 32'h06, 32'h77, 32'h0, 1'b1);
    add(1'b0, 32'h06, 32'h0, 32'h0, 1'b1);
    add(1'b0, 32'h02, 32'h0, 32'h0, 1'b1);
    add(1'b1, 32'h34, 32'h1, 32'h0, 1'b1);
    add(1'b0, 32'h04, 32'h0, 32'h55, 1'b0);
    add(1'b0, 32'h0C, 32'h0, 32'h0, 1'b0);

    // T1: dirty the state, then reset in the middle of a write access
    repeat (3) @(posedge pclk);
    #1 presetn = 1'b1;
    wr(32'h00, 32'h5);
    wr(32'h14, 32'h7);
    wr(32'h08, 32'h0F0F);
    psel = 1'b1; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h1234; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1;
    #2 presetn = 1'b0;
    #1 chk("rst_irq", 32'(irq), 32'h0);
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    chk("rst_pslverr", 32'(pslverr), 32'h0);
    presetn = 1'b1;
    @(posedge pclk); #1;

    // reset readback, T2 register access and T6 error vectors
    for (int i = 0; i < vt.size(); i++) begin
      apb(vt[i].wr, vt[i].addr, vt[i].data, r, e);
      chk($sformatf("v%0d_err", i), 32'(e), 32'(vt[i].err));
      if (!vt[i].wr) chk($sformatf("v%0d_rd", i), r, vt[i].rdata);
    end
    chk("idle_prdata", prdata, 32'h0);
    chk("tbl_irq", 32'(irq), 32'h0);

    // T3: PRESC=3, CMP=9, clear-on-compare: compare edge 40 cycles after commit, irq one later
    wr(32'h04, 32'h9);
    wr(32'h00, 32'h0);
    wr(32'h08, 32'h030B);
    repeat (40) @(posedge pclk);
    #1 chk("t3_irq_pre", 32'(irq), 32'h0);
    @(posedge pclk);
    #1 chk("t3_irq_rise", 32'(irq), 32'h2);
    rdc("t3_cnt_clr", 32'h00, 32'h0);
    rdc("t3_status", 32'h0C, 32'h2);
    wr(32'h0C, 32'h2);
    chk("t3_irq_hold", 32'(irq), 32'h2);
    @(posedge pclk);
    #1 chk("t3_irq_drop", 32'(irq), 32'h0);
    wr(32'h08, 32'h0);

    // T4: overflow then compare on timer 1, PRESC=3 ticks at commit+4,+8,+12
    wr(32'h10, 32'hFFFF_FFFE);
    wr(32'h14, 32'h0);
    wr(32'h18, 32'h0305);
    repeat (7) @(posedge pclk);
    #1;
    rdc("t4_status_ovf", 32'h1C, 32'h1);
    chk("t4_irq_ovf", 32'(irq), 32'h4);
    rdc("t4_cnt_wrap", 32'h10, 32'h0);
    rdc("t4_status_both", 32'h1C, 32'h3);
    chk("t4_irq_noie", 32'(irq), 32'h4);
    wr(32'h18, 32'h0);

    // T5a: compare every other edge; W1C on a compare edge loses, off it wins
    wr(32'h00, 32'h0);
    wr(32'h04, 32'h1);
    wr(32'h08, 32'h000B);
    wr(32'h0C, 32'h2);
    wr(32'h0C, 32'h2);
    rdc("t5_set_wins", 32'h0C, 32'h2);
    chk("t5_irq_kept", 32'(irq), 32'h2);
    @(posedge pclk); #1;
    wr(32'h0C, 32'h2);
    @(posedge pclk);
    #1 chk("t5_w1c_clears", 32'(irq), 32'h0);
    @(posedge pclk);
    #1 chk("t5_reset_again", 32'(irq), 32'h2);
    wr(32'h08, 32'h0);

    // T5b: CNT write on a tick edge wins, then disable holds the count
    wr(32'h10, 32'h0);
    wr(32'h14, 32'hFFFF_0000);
    wr(32'h18, 32'h1);
    wr(32'h10, 32'h100);
    rdc("t5_cnt_write_wins", 32'h10, 32'h101);
    wr(32'h18, 32'h0);
    repeat (3) @(posedge pclk);
    #1;
    rdc("t5_cnt_hold", 32'h10, 32'h104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
